// File: rtl/seg_pkg.sv
// Shared types, active-low segment encodings and the pattern decode function
// for the seven-segment scan reader.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURED = 2'd2
   } state_t;

   // Active-low patterns, bit6 = g ... bit0 = a
   localparam logic [6:0] SEG_0     = 7'b100_0000;
   localparam logic [6:0] SEG_1     = 7'b111_1001;
   localparam logic [6:0] SEG_2     = 7'b010_0100;
   localparam logic [6:0] SEG_3     = 7'b011_0000;
   localparam logic [6:0] SEG_4     = 7'b001_1001;
   localparam logic [6:0] SEG_5     = 7'b001_0010;
   localparam logic [6:0] SEG_6     = 7'b000_0010;
   localparam logic [6:0] SEG_7     = 7'b111_1000;
   localparam logic [6:0] SEG_8     = 7'b000_0000;
   localparam logic [6:0] SEG_9     = 7'b001_1000;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;

   // Returns {err, blank, bcd[3:0]}; blank and unknown patterns carry BCD F
   function automatic logic [5:0] seg_decode(input logic [6:0] pattern);
      logic [5:0] result;
      case (pattern)
         SEG_0:     result = {1'b0, 1'b0, 4'h0};
         SEG_1:     result = {1'b0, 1'b0, 4'h1};
         SEG_2:     result = {1'b0, 1'b0, 4'h2};
         SEG_3:     result = {1'b0, 1'b0, 4'h3};
         SEG_4:     result = {1'b0, 1'b0, 4'h4};
         SEG_5:     result = {1'b0, 1'b0, 4'h5};
         SEG_6:     result = {1'b0, 1'b0, 4'h6};
         SEG_7:     result = {1'b0, 1'b0, 4'h7};
         SEG_8:     result = {1'b0, 1'b0, 4'h8};
         SEG_9:     result = {1'b0, 1'b0, 4'h9};
         SEG_BLANK: result = {1'b0, 1'b1, 4'hF};
         default:   result = {1'b1, 1'b0, 4'hF};
      endcase
      return result;
   endfunction

endpackage

// File: rtl/seg_scan_reader_if.sv
// Display-bus sample inputs and decoded frame outputs of the scan reader.
// master = display side / consumer, slave = the reader itself.
interface seg_scan_reader_if #(
   parameter int NUM_DIGITS = 4
);
   logic [NUM_DIGITS-1:0]   anodes;
   logic [6:0]              segments;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_blank;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;

   modport master (
      output anodes, segments,
      input  digits, digit_blank, digit_err, frame_valid
   );

   modport slave (
      input  anodes, segments,
      output digits, digit_blank, digit_err, frame_valid
   );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern decoder, output {err, blank, bcd[3:0]}.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [5:0] decoded
);

   // Table lookup shared with any checker through the package function
   always_comb begin
      decoded = seg_decode(pattern);
   end

endmodule

// File: rtl/seg_scan_reader.sv
// Passive reader of a multiplexed active-low seven-segment bus: captures each
// settled digit slot and publishes a complete frame with a one-cycle valid pulse.
module seg_scan_reader
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 8,
   parameter int CNT_W         = 4
) (
   input logic              clk,
   input logic              reset_n,
   seg_scan_reader_if.slave bus
);

   localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [NUM_DIGITS-1:0]   anodes_r;
   logic [NUM_DIGITS-1:0]   prev_anodes_r;
   logic [6:0]              segments_r;
   logic [6:0]              prev_segments_r;

   state_t                  state_r;
   state_t                  state_s;
   logic [CNT_W-1:0]        count_r;
   logic [CNT_W-1:0]        count_s;

   logic                    onehot_s;
   logic                    same_s;
   logic [SLOT_W-1:0]       slot_s;
   logic [5:0]              dec_s;
   logic                    capture_s;
   logic                    frame_done_s;

   logic [4*NUM_DIGITS-1:0] stage_digits_r;
   logic [NUM_DIGITS-1:0]   stage_blank_r;
   logic [NUM_DIGITS-1:0]   stage_err_r;
   logic [NUM_DIGITS-1:0]   seen_r;
   logic [4*NUM_DIGITS-1:0] stage_digits_s;
   logic [NUM_DIGITS-1:0]   stage_blank_s;
   logic [NUM_DIGITS-1:0]   stage_err_s;
   logic [NUM_DIGITS-1:0]   seen_s;

   logic [4*NUM_DIGITS-1:0] digits_r;
   logic [NUM_DIGITS-1:0]   blank_r;
   logic [NUM_DIGITS-1:0]   err_r;
   logic                    frame_valid_r;

   seg_pattern_decode u_decode (
      .pattern (segments_r),
      .decoded (dec_s)
   );

   // Synchroniser stage plus the previous sample used for settle comparison
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         anodes_r        <= '1;
         prev_anodes_r   <= '1;
         segments_r      <= 7'h7F;
         prev_segments_r <= 7'h7F;
      end else begin
         anodes_r        <= bus.anodes;
         prev_anodes_r   <= anodes_r;
         segments_r      <= bus.segments;
         prev_segments_r <= segments_r;
      end
   end

   // Slot qualification and one-hot-low to binary slot index
   always_comb begin
      onehot_s = $onehot(~anodes_r);
      same_s   = (anodes_r == prev_anodes_r) && (segments_r == prev_segments_r);
      slot_s   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         slot_s = slot_s | (anodes_r[i] ? SLOT_W'(0) : SLOT_W'(i));
      end
   end

   // FSM state and settle counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         count_r <= '0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
      end
   end

   // FSM next state and settle counter update
   always_comb begin
      state_s = state_r;
      count_s = '0;
      case (state_r)
         IDLE: begin
            if (onehot_s) begin
               state_s = SETTLE;
            end else begin
               state_s = IDLE;
            end
         end
         SETTLE: begin
            if (!onehot_s) begin
               state_s = IDLE;
            end else if (!same_s) begin
               state_s = SETTLE;
            end else if (count_r == CNT_LAST) begin
               state_s = CAPTURED;
            end else begin
               state_s = SETTLE;
               count_s = count_r + 1'b1;
            end
         end
         CAPTURED: begin
            if (!onehot_s) begin
               state_s = IDLE;
            end else if (!same_s) begin
               state_s = SETTLE;
            end else begin
               state_s = CAPTURED;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM outputs: capture strobe, staging update and frame completion
   always_comb begin
      capture_s      = (state_r == SETTLE) && onehot_s && same_s && (count_r == CNT_LAST);
      stage_digits_s = stage_digits_r;
      stage_blank_s  = stage_blank_r;
      stage_err_s    = stage_err_r;
      seen_s         = seen_r;
      if (capture_s) begin
         stage_digits_s[{slot_s, 2'b00} +: 4] = dec_s[3:0];
         stage_blank_s[slot_s]                = dec_s[4];
         stage_err_s[slot_s]                  = dec_s[5];
         seen_s[slot_s]                       = 1'b1;
      end else begin
         seen_s = seen_r;
      end
      frame_done_s = capture_s && (&seen_s);
   end

   // Staging, seen mask and published frame registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_digits_r <= '0;
         stage_blank_r  <= '0;
         stage_err_r    <= '0;
         seen_r         <= '0;
         digits_r       <= '0;
         blank_r        <= '1;
         err_r          <= '0;
         frame_valid_r  <= 1'b0;
      end else begin
         stage_digits_r <= stage_digits_s;
         stage_blank_r  <= stage_blank_s;
         stage_err_r    <= stage_err_s;
         frame_valid_r  <= frame_done_s;
         if (frame_done_s) begin
            seen_r   <= '0;
            digits_r <= stage_digits_s;
            blank_r  <= stage_blank_s;
            err_r    <= stage_err_s;
         end else begin
            seen_r   <= seen_s;
         end
      end
   end

   assign bus.digits      = digits_r;
   assign bus.digit_blank = blank_r;
   assign bus.digit_err   = err_r;
   assign bus.frame_valid = frame_valid_r;

endmodule
